// File: rtl/pe_action_lut_pkg.sv
// pe_types: shared types for the processing element action table.
//
// Contents:
//   PAT_SIZE      default number of action table entries
//   PAT_NUM_RSVD  number of reserved PIDs (0..PAT_NUM_RSVD-1) that are never stored
//   PID_W         PID width; one bit wider than the table index so that
//                 out-of-range PIDs can be expressed and rejected
//   pid_t                 process identifier
//   action_table_entry_t  one action entry (opcode + destination)
//   scrub_state_e         scrub sequencer states
//   pid_legal()           true when a PID maps to a storable entry

package pe_types;

  localparam int PAT_SIZE     = 16;
  localparam int PAT_NUM_RSVD = 2;
  localparam int PID_W        = $clog2(PAT_SIZE) + 1;

  typedef logic [PID_W-1:0] pid_t;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] dest;
  } action_table_entry_t;

  typedef enum logic {
    SCRUB = 1'b0,
    IDLE  = 1'b1
  } scrub_state_e;

  // A PID is storable when it is above the reserved range and inside the table.
  function automatic logic pid_legal(input pid_t pid, input int depth, input int rsvd);
    return (int'(pid) >= rsvd) && (int'(pid) < depth);
  endfunction

endpackage

// File: rtl/pe_action_lut_scrubber.sv
// pe_lut_scrubber: scrub sequencer for pe_action_lut.
//
// After reset, or when clr_req arrives while idle, walks idx from NUM_RSVD to
// DEPTH-1, asserting clr_en for one entry per cycle, then returns to IDLE.
// clr_req while scrubbing is ignored.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr_req    request a full scrub (honoured only in IDLE)
//   busy       scrub in progress
//   clr_en     clear strobe for entry clr_idx this cycle
//   clr_idx    entry being cleared

module pe_lut_scrubber
  import pe_types::*;
#(
  parameter int DEPTH    = PAT_SIZE,
  parameter int NUM_RSVD = PAT_NUM_RSVD,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NUM_RSVD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  scrub_state_e     state, state_next;
  logic [IDX_W-1:0] idx, idx_next;

  // State and index registers; reset lands directly in SCRUB so the array is
  // cleaned before any write can be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCRUB;
      idx   <= FIRST_IDX;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic: one entry per cycle in SCRUB, leave after the last one.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    busy       = 1'b0;
    clr_en     = 1'b0;
    clr_idx    = idx;
    case (state)
      SCRUB: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_next = SCRUB;
          idx_next   = FIRST_IDX;
        end
      end
      default: begin
        state_next = SCRUB;
        idx_next   = FIRST_IDX;
      end
    endcase
  end

endmodule

// File: rtl/pe_action_lut.sv
// pe_action_lut: multi-read-port action table for the processing element.
//
// Per-PID action entries with explicit valid bits, NUM_RD registered read
// ports (1-cycle latency), a ready/valid write port with invalidate, and a
// scrub sequencer (pe_lut_scrubber) that clears the table after reset or on
// clr_req. Writes stall (wr_ready=0) and reads miss while scrubbing.
//
// Configuration macro:
//   PE_LUT_BYPASS_EN  defined: a read hitting the PID of a same-cycle accepted
//                     legal write returns the new value (or a miss on kill).
//                     undefined: such a read returns the pre-write contents.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_valid/wr_ready        write handshake
//   wr_pid, wr_kill, wr_entry  write target, invalidate flag, data
//   wr_err                   pulse: accepted write hit a reserved/out-of-range PID
//   rd_en[p], rd_pid[p]      read strobe and PID per port
//   rsp_valid/hit/entry[p]   registered read response per port
//   clr_req                  request full scrub
//   busy                     scrub in progress
//   valid_cnt                number of valid entries

module pe_action_lut
  import pe_types::*;
#(
  parameter int DEPTH    = PAT_SIZE,
  parameter int NUM_RSVD = PAT_NUM_RSVD,
  parameter int NUM_RD   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  pid_t                       wr_pid,
  input  logic                       wr_kill,
  input  action_table_entry_t        wr_entry,
  output logic                       wr_err,
  input  logic [NUM_RD-1:0]          rd_en,
  input  pid_t                       rd_pid [NUM_RD],
  output logic [NUM_RD-1:0]          rsp_valid,
  output logic [NUM_RD-1:0]          rsp_hit,
  output action_table_entry_t        rsp_entry [NUM_RD],
  input  logic                       clr_req,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] valid_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  action_table_entry_t data [DEPTH];
  logic [DEPTH-1:0]    vld;

  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;

  logic             wr_fire;
  logic             wr_legal;
  logic             wr_bad;
  logic [IDX_W-1:0] wr_idx;
  logic             cnt_inc;
  logic             cnt_dec;

  logic                rd_hit_c   [NUM_RD];
  action_table_entry_t rd_entry_c [NUM_RD];

  pe_lut_scrubber #(
    .DEPTH    (DEPTH),
    .NUM_RSVD (NUM_RSVD),
    .IDX_W    (IDX_W)
  ) u_scrubber (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  assign wr_ready = ~busy;

  // Write decode. Illegal PIDs are still accepted (so the writer is never
  // stuck) but only raise wr_err. The valid counter moves on real vld edges
  // only, so rewrites and repeated kills leave it alone.
  always_comb begin
    wr_fire  = wr_valid && wr_ready;
    wr_legal = wr_fire && pid_legal(wr_pid, DEPTH, NUM_RSVD);
    wr_bad   = wr_fire && !pid_legal(wr_pid, DEPTH, NUM_RSVD);
    wr_idx   = wr_pid[IDX_W-1:0];
    cnt_inc  = wr_legal && !wr_kill && !vld[wr_idx];
    cnt_dec  = (clr_en && vld[clr_idx]) || (wr_legal && wr_kill && vld[wr_idx]);
  end

  // Data array carries no reset; the scrub provides the clean contents.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      data[clr_idx] <= '0;
    end else if (wr_legal && !wr_kill) begin
      data[wr_idx] <= wr_entry;
    end
  end

  // Valid bits, counter and error pulse. Reserved vld bits are never written
  // after reset, so they stay 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      valid_cnt <= '0;
      wr_err    <= 1'b0;
    end else begin
      if (clr_en) begin
        vld[clr_idx] <= 1'b0;
      end else if (wr_legal) begin
        vld[wr_idx] <= !wr_kill;
      end
      if (cnt_inc && !cnt_dec) begin
        valid_cnt <= valid_cnt + CNT_W'(1);
      end else if (cnt_dec && !cnt_inc) begin
        valid_cnt <= valid_cnt - CNT_W'(1);
      end
      wr_err <= wr_bad;
    end
  end

  // Read lookup per port. Anything during a scrub, or to a reserved or
  // out-of-range PID, is a miss with zero data.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_hit_c[p]   = 1'b0;
      rd_entry_c[p] = '0;
      if (!busy && pid_legal(rd_pid[p], DEPTH, NUM_RSVD)) begin
        rd_hit_c[p] = vld[rd_pid[p][IDX_W-1:0]];
        if (rd_hit_c[p]) begin
          rd_entry_c[p] = data[rd_pid[p][IDX_W-1:0]];
        end
      end
`ifdef PE_LUT_BYPASS_EN
      if (wr_legal && (wr_pid == rd_pid[p])) begin
        rd_hit_c[p]   = !wr_kill;
        rd_entry_c[p] = wr_kill ? '0 : wr_entry;
      end
`endif
    end
  end

  // Registered responses, held for exactly one cycle per read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_hit   <= '0;
      for (int p = 0; p < NUM_RD; p++) begin
        rsp_entry[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        rsp_valid[p] <= rd_en[p];
        rsp_hit[p]   <= rd_en[p] && rd_hit_c[p];
        rsp_entry[p] <= rd_en[p] ? rd_entry_c[p] : '0;
      end
    end
  end

endmodule

// File: tb/tb_pe_action_lut.sv
// tb_pe_action_lut: directed self-checking bench for pe_action_lut
// (DEPTH=16, NUM_RSVD=2, NUM_RD=2). Inputs change and outputs are sampled on
// the falling clock edge.

module tb_pe_action_lut;
  import pe_types::*;

  logic                clk;
  logic                rst;
  logic                wr_valid;
  logic                wr_ready;
  pid_t                wr_pid;
  logic                wr_kill;
  action_table_entry_t wr_entry;
  logic                wr_err;
  logic [1:0]          rd_en;
  pid_t                rd_pid [2];
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_hit;
  action_table_entry_t rsp_entry [2];
  logic                clr_req;
  logic                busy;
  logic [4:0]          valid_cnt;

  int checks = 0;
  int errors = 0;
  int cycles;

  pe_action_lut #(
    .DEPTH    (16),
    .NUM_RSVD (2),
    .NUM_RD   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_pid    (wr_pid),
    .wr_kill   (wr_kill),
    .wr_entry  (wr_entry),
    .wr_err    (wr_err),
    .rd_en     (rd_en),
    .rd_pid    (rd_pid),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_entry (rsp_entry),
    .clr_req   (clr_req),
    .busy      (busy),
    .valid_cnt (valid_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One write beat; the posedge inside accepts it when wr_ready is high.
  task automatic do_write(input int pid, input logic kill, input logic [7:0] val);
    wr_valid = 1'b1;
    wr_pid   = pid_t'(pid);
    wr_kill  = kill;
    wr_entry = action_table_entry_t'(val);
    tick();
    wr_valid = 1'b0;
    wr_kill  = 1'b0;
  endtask

  // One read beat on both ports; response is visible on return.
  task automatic do_read(input logic [1:0] en, input int pid0, input int pid1);
    rd_en     = en;
    rd_pid[0] = pid_t'(pid0);
    rd_pid[1] = pid_t'(pid1);
    tick();
    rd_en = 2'b00;
  endtask

  // Counts busy cycles from the current falling edge; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_pid    = '0;
    wr_kill   = 1'b0;
    wr_entry  = '0;
    rd_en     = 2'b00;
    rd_pid[0] = '0;
    rd_pid[1] = '0;
    clr_req   = 1'b0;

    // Reset values.
    #2;
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check("rst_rsp_entry0", 32'(rsp_entry[0]), 32'd0);
    check("rst_valid_cnt", 32'(valid_cnt), 32'd0);

    // Initial scrub: 14 busy cycles, then ready.
    tick();
    rst = 1'b0;
    count_busy(cycles);
    check("scrub_len", 32'(cycles), 32'd14);
    check("ready_after_scrub", 32'(wr_ready), 32'd1);
    check("cnt_after_scrub", 32'(valid_cnt), 32'd0);

    // Empty table read; port 1 out of range.
    do_read(2'b11, 5, 20);
    check("rd5_valid", 32'(rsp_valid), 32'b11);
    check("rd5_hit", 32'(rsp_hit), 32'b00);
    check("rd5_entry", 32'(rsp_entry[0]), 32'd0);

    // Write then read on both ports.
    do_write(3, 1'b0, 8'hA5);
    do_read(2'b11, 3, 3);
    check("rd3_hit", 32'(rsp_hit), 32'b11);
    check("rd3_entry0", 32'(rsp_entry[0]), 32'hA5);
    check("rd3_entry1", 32'(rsp_entry[1]), 32'hA5);
    check("cnt_one", 32'(valid_cnt), 32'd1);

    // Response held one cycle only.
    tick();
    check("idle_rsp_valid", 32'(rsp_valid), 32'b00);
    check("idle_rsp_hit", 32'(rsp_hit), 32'b00);
    check("idle_rsp_entry", 32'(rsp_entry[0]), 32'd0);

    // Rewrite of a valid entry.
    do_write(3, 1'b0, 8'h5A);
    check("rewrite_cnt", 32'(valid_cnt), 32'd1);
    do_read(2'b01, 3, 0);
    check("rewrite_entry", 32'(rsp_entry[0]), 32'h5A);

    // Reserved and out-of-range writes.
    do_write(1, 1'b0, 8'hFF);
    check("rsvd_wr_err", 32'(wr_err), 32'd1);
    check("rsvd_cnt", 32'(valid_cnt), 32'd1);
    tick();
    check("wr_err_pulse", 32'(wr_err), 32'd0);
    do_read(2'b10, 0, 1);
    check("rsvd_rd_valid", 32'(rsp_valid), 32'b10);
    check("rsvd_rd_hit", 32'(rsp_hit), 32'b00);
    do_write(17, 1'b0, 8'h11);
    check("oor_wr_err", 32'(wr_err), 32'd1);
    check("oor_cnt", 32'(valid_cnt), 32'd1);

    // Kill, then kill again.
    do_write(3, 1'b1, 8'h00);
    check("kill_cnt", 32'(valid_cnt), 32'd0);
    do_read(2'b01, 3, 0);
    check("kill_hit", 32'(rsp_hit), 32'b00);
    check("kill_entry", 32'(rsp_entry[0]), 32'd0);
    do_write(3, 1'b1, 8'h00);
    check("rekill_cnt", 32'(valid_cnt), 32'd0);

    // Same-cycle write and read of PID 7.
    rd_en     = 2'b01;
    rd_pid[0] = pid_t'(7);
    do_write(7, 1'b0, 8'h3C);
    rd_en = 2'b00;
`ifdef PE_LUT_BYPASS_EN
    check("same_cyc_hit", 32'(rsp_hit), 32'b01);
    check("same_cyc_entry", 32'(rsp_entry[0]), 32'h3C);
`else
    check("same_cyc_hit", 32'(rsp_hit), 32'b00);
    check("same_cyc_entry", 32'(rsp_entry[0]), 32'd0);
`endif
    do_read(2'b01, 7, 0);
    check("after_wr7_hit", 32'(rsp_hit), 32'b01);
    check("after_wr7_entry", 32'(rsp_entry[0]), 32'h3C);

    // Fill every legal PID.
    for (int pid = 2; pid < 16; pid++) begin
      do_write(pid, 1'b0, 8'(8'h40 + pid));
    end
    check("fill_cnt", 32'(valid_cnt), 32'd14);
    do_read(2'b11, 9, 15);
    check("fill_entry9", 32'(rsp_entry[0]), 32'h49);
    check("fill_entry15", 32'(rsp_entry[1]), 32'h4F);

    // Scrub on request with a stalled write and a mid-scrub clr_req.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_wr_ready", 32'(wr_ready), 32'd0);
    check("clr_cnt_start", 32'(valid_cnt), 32'd14);
    wr_valid  = 1'b1;
    wr_pid    = pid_t'(4);
    wr_kill   = 1'b0;
    wr_entry  = action_table_entry_t'(8'h77);
    rd_en     = 2'b01;
    rd_pid[0] = pid_t'(9);
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      rd_en   = 2'b00;
      if (k == 1) begin
        check("busy_rd_valid", 32'(rsp_valid), 32'b01);
        check("busy_rd_hit", 32'(rsp_hit), 32'b00);
        check("busy_rd_entry", 32'(rsp_entry[0]), 32'd0);
      end
      check("scrub_cnt", 32'(valid_cnt), 32'(14 - k));
      check("scrub_busy", 32'(busy), (k < 14) ? 32'd1 : 32'd0);
      check("scrub_ready", 32'(wr_ready), (k < 14) ? 32'd0 : 32'd1);
    end
    tick();
    wr_valid = 1'b0;
    check("stalled_wr_cnt", 32'(valid_cnt), 32'd1);
    do_read(2'b11, 4, 5);
    check("post_scrub_hit", 32'(rsp_hit), 32'b01);
    check("post_scrub_entry", 32'(rsp_entry[0]), 32'h77);

    // Reset in the middle of a scrub (idx=9).
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    check("mid_scrub_busy", 32'(busy), 32'd1);
    rd_en = 2'b11;
    rst   = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_ready", 32'(wr_ready), 32'd0);
    check("mid_rst_cnt", 32'(valid_cnt), 32'd0);
    tick();
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'b00);
    check("mid_rst_wr_err", 32'(wr_err), 32'd0);
    rd_en = 2'b00;
    rst   = 1'b0;
    count_busy(cycles);
    check("restart_scrub_len", 32'(cycles), 32'd14);
    check("restart_ready", 32'(wr_ready), 32'd1);
    do_read(2'b01, 4, 0);
    check("restart_hit4", 32'(rsp_hit), 32'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_action_lut.md
# pe_action_lut

Parametrised, multi-read-port successor to the processing element's action table. Holds per-PID action entries with explicit valid bits, a registered (1-cycle) read per port, a ready/valid write port with invalidate, and a hardware scrub sequencer that zeroes the array after reset or on request. Sits between the PE config path (writer) and the PE arbiter/dispatch stages (readers), which consume `rsp_*` as registered outputs.

## Interface
Parameters:
- `DEPTH`, `PAT_SIZE`: number of table entries, PID range 0..DEPTH-1.
- `NUM_RSVD`, 2: PIDs 0..NUM_RSVD-1 are reserved, never stored.
- `NUM_RD`, 2: independent read ports.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when `wr_valid && wr_ready`.
- `wr_pid` in `pid_t`: write target.
- `wr_kill` in 1: 1 = invalidate entry, 0 = store `wr_entry`.
- `wr_entry` in `action_table_entry_t`: write data.
- `wr_err` out 1: one-cycle pulse, accepted write hit a reserved or out-of-range PID.
- `rd_en` in [NUM_RD]: per-port read strobe.
- `rd_pid` in [NUM_RD] `pid_t`: per-port read PID.
- `rsp_valid` out [NUM_RD]: response valid, 1 cycle after `rd_en`.
- `rsp_hit` out [NUM_RD]: entry valid at read time.
- `rsp_entry` out [NUM_RD] `action_table_entry_t`: entry data, zero on miss.
- `clr_req` in 1: request a full scrub.
- `busy` out 1: scrub in progress.
- `valid_cnt` out `$clog2(DEPTH+1)`: number of valid entries.

## Operation
- Storage: data array without reset, plus `vld[DEPTH]` flops with async reset to 0. Entries 0..NUM_RSVD-1 have no storage. `vld` of reserved PIDs is constant 0.
- FSM states: `SCRUB`, `IDLE`.
  - Reset goes to `SCRUB` with `idx=NUM_RSVD`.
  - In `SCRUB`: `data[idx]<=0`, `vld[idx]<=0`, `idx++` each cycle.
  - When `idx==DEPTH-1` has been cleared, go to `IDLE`.
  - In `IDLE`: `clr_req` goes to `SCRUB` with `idx=NUM_RSVD`. `clr_req` during `SCRUB` is ignored and does not restart the scrub.
- `wr_ready = (state==IDLE)`. `busy = (state==SCRUB)`.
- Accepted write to a legal PID:
  - `wr_kill=0`: `data<=wr_entry`, `vld<=1`.
  - `wr_kill=1`: `vld<=0`, data unchanged.
- Accepted write to a reserved PID or PID≥DEPTH: no state change; `wr_err` pulses the next cycle.
- `valid_cnt` tracks `vld` transitions:
  - +1 on a 0→1 transition; −1 on a 1→0 transition.
  - Rewriting an already-valid entry leaves it unchanged.
  - A scrub decrements per cleared valid entry, so it reaches 0 at scrub end.
- Reads, per port, independent:
  - `rsp_hit` = `vld[rd_pid]`; `rsp_entry` = `data[rd_pid]` if hit, else 0.
  - Reserved, out-of-range, or any read while `busy`: `hit=0`, `entry=0`, `rsp_valid` still 1.
- Read and write to the same PID in the same cycle: behaviour set by the Configuration macro.

## Timing
- Reset values: `wr_ready=0`, `busy=1`, `wr_err=0`, `rsp_valid=0`, `rsp_hit=0`, `rsp_entry=0`, `valid_cnt=0`, `state=SCRUB`.
- Scrub lasts DEPTH−NUM_RSVD cycles. `wr_ready` rises the cycle after the last entry is cleared.
- Write: visible to reads issued the following cycle (a 1-cycle write-to-read turnaround without bypass).
- Read latency: exactly 1 cycle, with registered outputs. `rsp_*` is held for 1 cycle only; with `rd_en=0`, `rsp_valid=0` and `hit`/`entry` return to 0.
- `rst` mid-scrub or mid-write: the scrub restarts from `NUM_RSVD`. A write in flight is lost and is not acknowledged.

## Configuration
- `PE_LUT_BYPASS_EN` defined: a read in the same cycle as an accepted legal write to the same PID returns the new value.
  - `wr_kill=0`: `hit=1`, `entry=wr_entry`.
  - `wr_kill=1`: `hit=0`, `entry=0`.
- `PE_LUT_BYPASS_EN` undefined: the same-cycle read returns the pre-write contents.

## Structure
- `pe_types` package holds `pid_t`, `action_table_entry_t`, `PAT_SIZE`, and a new `PAT_NUM_RSVD=2`.
- One sub-module, `pe_lut_scrubber`, contains the FSM, `idx` counter, `busy` and the clear strobes.
- The array, valid bits, counter and read ports live in the top module.

## Test plan
- Reset, DEPTH=16 → `busy` for 14 cycles, `wr_ready` rises on cycle 15, `valid_cnt=0`; read of PID 5 gives `rsp_valid=1`, `hit=0`, `entry=0`.
- Write PID 3 = 0xA5, then read PID 3 on both ports the next cycle → both ports `hit=1`, `entry=0xA5`, `valid_cnt=1`; a rewrite keeps `valid_cnt=1`.
- Write PID 1 → `wr_err` pulses, no state change; read PID 1 → `hit=0`.
- Same-cycle write PID 7 = 0x3C and read PID 7 → `entry=0x3C` with `PE_LUT_BYPASS_EN`, `hit=0` without it.
- Fill PIDs 2–15, assert `clr_req` → `valid_cnt` counts 14→0 over 14 cycles; writes during scrub stall with `wr_ready=0`; `clr_req` mid-scrub does not extend the scrub.
- Assert `rst` mid-scrub at `idx=9` → the scrub restarts at 2 and all outputs take their reset values.
